// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU load/store path: access size encodings,
// the data-memory controller FSM states and the byte-lane count of a word.
package cpu_mem_pkg;

    // Access size as carried on the load/store port; 2'b11 is never legal.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte lanes per 32-bit word (width of a byte-enable mask).
    localparam int LANE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for 32-bit little-endian memories.
//   size, unsigned_ld : access size and load extension mode
//   offset            : byte offset of the access within the word
//   wdata             : right-justified store data
//   rword             : word currently held in memory
//   be, wword         : store byte enables and lane-replicated store data
//   ldata             : load result, right-justified and extended
// Alignment is not checked here; the caller rejects misaligned accesses.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [1:0]        offset,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rword,
    output logic [LANE_W-1:0] be,
    output logic [31:0]       wword,
    output logic [31:0]       ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be     = '0;
        wword  = wdata;
        ldata  = '0;
        byte_v = '0;
        half_v = '0;
        case (size)
            SZ_BYTE: begin
                // Replicate the byte so whichever lane is enabled sees it.
                be     = 4'b0001 << offset;
                wword  = {4{wdata[7:0]}};
                byte_v = rword[{offset, 3'b000} +: 8];
                ldata  = unsigned_ld ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be     = offset[1] ? 4'b1100 : 4'b0011;
                wword  = {2{wdata[15:0]}};
                half_v = offset[1] ? rword[31:16] : rword[15:0];
                ldata  = unsigned_ld ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                be    = '1;
                wword = wdata;
                ldata = rword;
            end
            default: begin
                be    = '0;
                ldata = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the CPU load/store port. One request at a time
// over req/ready, a fixed number of wait states per legal access, byte/half/
// word stores with lane masking, sign/zero-extended loads, and rejection of
// misaligned or out-of-range accesses without touching memory.
//   clk, rst          : clock, synchronous active-low reset
//   req, we, size     : request valid (sampled in IDLE), store select, size
//   unsigned_ld       : zero-extend loads when 1
//   addr, wdata       : byte address, right-justified store data
//   rdata             : load result, registered, held until next response
//   ready, err        : one-cycle completion pulse and its error qualifier
//   busy              : controller not idle; the CPU stalls on it
module dmem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    mem_state_t state, next_state;
    logic [2:0] cnt;

    // Request captured at accept time, used while waiting.
    logic        c_we, c_uns;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;

    // The access under evaluation: live inputs in IDLE, captured ones after.
    logic        cur_we, cur_uns;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;

    logic [32:0]       diff;
    logic [31:0]       off;
    logic              in_range, legal, take, do_access, wr_en;
    logic [AW-1:0]     idx;
    logic [LANE_W-1:0] be;
    logic [31:0]       wword, ldata, rword;

    logic [31:0] mem [DEPTH_WORDS];

    assign cur_we    = (state == ST_IDLE) ? we          : c_we;
    assign cur_uns   = (state == ST_IDLE) ? unsigned_ld : c_uns;
    assign cur_size  = (state == ST_IDLE) ? size        : c_size;
    assign cur_addr  = (state == ST_IDLE) ? addr        : c_addr;
    assign cur_wdata = (state == ST_IDLE) ? wdata       : c_wdata;

    // 33-bit subtraction: the borrow bit flags addresses below the base.
    assign diff     = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign off      = diff[31:0];
    assign in_range = !diff[32] && (off < SPAN);
    assign legal    = in_range
                   && (cur_size != 2'b11)
                   && !(cur_size == SZ_HALF && cur_addr[0])
                   && !(cur_size == SZ_WORD && cur_addr[1:0] != 2'b00);

    // BASE_ADDR is aligned to the array span, so off[1:0] == addr[1:0].
    assign idx   = off[AW+1:2];
    assign rword = mem[idx];
    assign take  = (state == ST_IDLE) && req;
    assign wr_en = do_access && cur_we;
    assign busy  = (state != ST_IDLE);

    mem_lane_align u_align (
        .size        (cur_size),
        .unsigned_ld (cur_uns),
        .offset      (off[1:0]),
        .wdata       (cur_wdata),
        .rword       (rword),
        .be          (be),
        .wword       (wword),
        .ldata       (ldata)
    );

    always_comb begin
        next_state = state;
        do_access  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (!legal) begin
                        next_state = ST_RESP;
                    end else if (WAIT_STATES == 0) begin
                        next_state = ST_RESP;
                        do_access  = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            // Only legal accesses ever reach WAIT.
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    next_state = ST_RESP;
                    do_access  = 1'b1;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            c_we    <= 1'b0;
            c_uns   <= 1'b0;
            c_size  <= 2'b00;
            c_addr  <= '0;
            c_wdata <= '0;
        end else begin
            state <= next_state;
            ready <= (next_state == ST_RESP);
            err   <= take && !legal;
            if (next_state == ST_RESP)
                rdata <= (do_access && !cur_we) ? ldata : 32'd0;
            if (take) begin
                c_we    <= we;
                c_uns   <= unsigned_ld;
                c_size  <= size;
                c_addr  <= addr;
                c_wdata <= wdata;
                cnt     <= CNT_INIT;
            end else if (state == ST_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Byte-write array with no reset. Gating on rst drops a store whose
    // commit edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            for (int i = 0; i < LANE_W; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Two instances (0 and 3 wait states)
// share the clock and are driven independently; a byte-array model of each
// memory supplies expected load data, legality and latency.
module tb_dmem_ctrl;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_s, req_s, we_s, uns_s, ready_s, err_s, busy_s;
    logic [1:0][1:0]  size_s;
    logic [1:0][31:0] addr_s, wdata_s, rdata_s;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
        .unsigned_ld(uns_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
        .unsigned_ld(uns_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1])
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [2][DEPTH*4];

    function automatic int ws(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic logic model_legal(input logic [1:0] sz, input logic [31:0] a);
        logic [63:0] av, lo, hi;
        av = {32'd0, a};
        lo = {32'd0, BASE};
        hi = lo + 64'(4 * DEPTH);
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b0;
        if (sz == 2'b10 && (a % 4) != 0) return 1'b0;
        return (av >= lo) && (av < hi);
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a);
        int n, off;
        logic [31:0] v;
        n = 1 << sz;
        off = int'(a - BASE);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[s][off+i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic void model_store(input int s, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] d);
        int n, off;
        n = 1 << sz;
        off = int'(a - BASE);
        for (int i = 0; i < n; i++) mb[s][off+i] = d[8*i +: 8];
    endfunction

    // One complete transaction on instance s, checked against the model.
    task automatic access(input int s, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        logic legal;
        logic [31:0] exp;
        int exp_lat, cyc;
        legal   = model_legal(sz, a);
        exp     = (legal && !w) ? model_load(s, sz, u, a) : 32'd0;
        exp_lat = legal ? ws(s) + 1 : 1;
        @(negedge clk);
        checks++;
        if (busy_s[s] !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy dut%0d got %b want 0", s, busy_s[s]);
        end
        req_s[s] = 1'b1; we_s[s] = w; size_s[s] = sz; uns_s[s] = u;
        addr_s[s] = a; wdata_s[s] = d;
        @(posedge clk);
        #1 req_s[s] = 1'b0;
        cyc = 1;
        while (ready_s[s] !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (ready_s[s] !== 1'b1 || cyc != exp_lat) begin
            errors++;
            $display("FAIL latency dut%0d a=%h got %0d want %0d", s, a, cyc, exp_lat);
        end
        checks++;
        if (err_s[s] !== !legal) begin
            errors++;
            $display("FAIL err dut%0d a=%h sz=%0d got %b want %b", s, a, sz, err_s[s], !legal);
        end
        checks++;
        if (rdata_s[s] !== exp) begin
            errors++;
            $display("FAIL rdata dut%0d a=%h sz=%0d u=%b got %h want %h", s, a, sz, u, rdata_s[s], exp);
        end
        got = rdata_s[s];
        if (legal && w) model_store(s, sz, a, d);
        @(posedge clk);
        #1;
        checks++;
        if (ready_s[s] !== 1'b0 || err_s[s] !== 1'b0 || busy_s[s] !== 1'b0 || rdata_s[s] !== exp) begin
            errors++;
            $display("FAIL pulse_hold dut%0d got rdy=%b err=%b busy=%b rd=%h want 0 0 0 %h",
                     s, ready_s[s], err_s[s], busy_s[s], rdata_s[s], exp);
        end
    endtask

    task automatic test_reset();
        rst_s = 2'b00; req_s = '0; we_s = '0; uns_s = '0; size_s = '0; addr_s = '0; wdata_s = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({ready_s[s], err_s[s], busy_s[s]} !== 3'b000 || rdata_s[s] !== 32'd0) begin
                errors++;
                $display("FAIL reset dut%0d got rdy=%b err=%b busy=%b rd=%h want all 0",
                         s, ready_s[s], err_s[s], busy_s[s], rdata_s[s]);
            end
        end
        @(negedge clk);
        rst_s = 2'b11;
    endtask

    task automatic test_init();
        logic [31:0] g;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++)
                access(s, 1'b1, 2'b10, 1'b0, BASE + 32'(4*w), $urandom, g);
    endtask

    task automatic test_basic();
        logic [31:0] g;
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, g);
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
        checks++;
        if (g !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_lw got %h want deadbeef", g);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] g;
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, g);
        access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680, g);
        access(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, g);
        checks++;
        if (g !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h want ffffff80", g); end
        access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, g);
        checks++;
        if (g !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", g); end
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
        checks++;
        if (g !== 32'h8000_0000) begin errors++; $display("FAIL sb_word got %h want 80000000", g); end
    endtask

    task automatic test_half_lanes();
        logic [31:0] g;
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_BABE, g);
        access(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h7777_8001, g);
        access(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, g);
        checks++;
        if (g !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", g); end
        access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, g);
        checks++;
        if (g !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h want 00008001", g); end
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, g);
        checks++;
        if (g !== 32'h8001_BABE) begin errors++; $display("FAIL sh_word got %h want 8001babe", g); end
    endtask

    // Illegal requests: latency, err and zero rdata come from the model;
    // the follow-up loads show memory was not disturbed.
    task automatic test_errors();
        logic [31:0] g;
        for (int s = 0; s < 2; s++) begin
            access(s, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, g);
            access(s, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, g);
            access(s, 1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF, g);
            access(s, 1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, g);
            access(s, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, g);
            access(s, 1'b1, 2'b10, 1'b0, BASE + 32'(4*DEPTH), 32'hFFFF_FFFF, g);
            access(s, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
            access(s, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, g);
            access(s, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, g);
        end
    endtask

    // req held high on the 3-wait-state instance: response every 5 cycles.
    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = model_load(1, 2'b10, 1'b0, 32'h20);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; size_s[1] = 2'b10; uns_s[1] = 1'b0; addr_s[1] = 32'h20;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++;
            if (ready_s[1] !== (k % 5 == 4) || busy_s[1] !== (k % 5 != 0)) begin
                errors++;
                $display("FAIL b2b cycle %0d got rdy=%b busy=%b want %b %b",
                         k, ready_s[1], busy_s[1], (k % 5 == 4), (k % 5 != 0));
            end
            if (k % 5 == 4) begin
                checks++;
                if (rdata_s[1] !== exp) begin
                    errors++;
                    $display("FAIL b2b_rdata cycle %0d got %h want %h", k, rdata_s[1], exp);
                end
            end
            if (k == 10) req_s[1] = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] g;
        access(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_0F0F, g);
        access(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, g);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b1; size_s[1] = 2'b10; addr_s[1] = 32'h30; wdata_s[1] = 32'h1234_5678;
        @(posedge clk);
        #1 req_s[1] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if (ready_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
                errors++;
                $display("FAIL mid_wait cycle %0d got rdy=%b busy=%b want 0 1", k, ready_s[1], busy_s[1]);
            end
            if (k == 1) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        rst_s[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ready_s[1], err_s[1], busy_s[1]} !== 3'b000 || rdata_s[1] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b err=%b busy=%b rd=%h want all 0",
                     ready_s[1], err_s[1], busy_s[1], rdata_s[1]);
        end
        @(negedge clk);
        rst_s[1] = 1'b1;
        access(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, g);
        checks++;
        if (g !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mid_old got %h want a5a50f0f", g); end
    endtask

    task automatic test_random();
        logic [31:0] g, a;
        logic [1:0] sz;
        int r;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 60; n++) begin
                r  = int'($urandom_range(0, 9));
                sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                a  = ($urandom_range(0, 15) == 0) ? $urandom : BASE + $urandom_range(0, 4*DEPTH + 15);
                access(s, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_byte_lanes();
        test_half_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
